// File: rtl/aes_block_loader.sv
// aes_block_loader
//   Assembles a byte-wide plaintext stream into 128-bit blocks for the AES core.
//   The final partial block of a message is padded, either with zeros or with
//   PKCS#7 bytes. Each block is paired with a snapshot of the key shadow
//   register and offered downstream over a valid/ready handshake.
//   All outputs are registered, so there is no combinational path from
//   in_valid to blk_valid or from blk_ready to in_ready.

module aes_block_loader #(
  parameter int PAD_MODE  = 0,  // 0: pad with 8'h00, 1: PKCS#7
  parameter int MSB_FIRST = 1   // 1: byte 0 in [127:120], 0: byte 0 in [7:0]
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic [127:0] blk_data,
  output logic [127:0] blk_key,
  output logic [4:0]   blk_count,
  output logic         blk_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         busy
);

  typedef enum logic [1:0] {
    FILL = 2'd0,  // accepting plaintext bytes
    PAD  = 2'd1,  // writing pad bytes up to a full block
    HOLD = 2'd2   // block presented downstream, waiting for blk_ready
  } state_e;

  localparam logic [4:0] BLOCK_BYTES = 5'd16;
  localparam logic [4:0] LAST_INDEX  = 5'd15;

  state_e       state_q,      state_d;
  logic [4:0]   cnt_q,        cnt_d;
  logic [127:0] data_q,       data_d;
  logic [127:0] key_shadow_q, key_shadow_d;
  logic [127:0] blk_key_q,    blk_key_d;
  logic [4:0]   blk_count_q,  blk_count_d;
  logic         blk_last_q,   blk_last_d;
  logic         extra_pad_q,  extra_pad_d;
  logic         in_ready_q,   in_ready_d;
  logic         blk_valid_q,  blk_valid_d;
  logic         busy_q,       busy_d;

  // Byte-write port into the block register, driven by the FSM below.
  logic         wr_en;
  logic [7:0]   wr_byte;
  logic [7:0]   pad_byte;

  // PKCS#7 pad value is the number of pad bytes; for the extra block
  // blk_count is 0, which yields 16 = 8'h10.
  always_comb begin
    pad_byte = 8'h00;
    if (PAD_MODE != 0) begin
      pad_byte = {3'b000, BLOCK_BYTES - blk_count_q};
    end
  end

  // Next-state logic: FSM, byte counter, block metadata and key snapshot.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first so that
    // no path leaves it unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    blk_key_d    = blk_key_q;
    blk_count_d  = blk_count_q;
    blk_last_d   = blk_last_q;
    extra_pad_d  = extra_pad_q;
    wr_en        = 1'b0;
    wr_byte      = 8'h00;

    // The shadow register follows key_load in every state.
    key_shadow_d = key_load ? key_in : key_shadow_q;

    unique case (state_q)
      FILL: begin
        if (in_valid && in_ready_q) begin
          wr_en   = 1'b1;
          wr_byte = in_data;
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == LAST_INDEX) begin
            // 16th byte: block is full, no padding needed in this block.
            state_d     = HOLD;
            blk_count_d = BLOCK_BYTES;
            blk_last_d  = in_last && (PAD_MODE == 0);
            // PKCS#7 always pads, so an exact fill needs a whole extra block.
            extra_pad_d = in_last && (PAD_MODE != 0);
          end else if (in_last) begin
            state_d     = PAD;
            blk_count_d = cnt_q + 5'd1;
            blk_last_d  = 1'b1;
          end
        end
      end

      PAD: begin
        wr_en   = 1'b1;
        wr_byte = pad_byte;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == LAST_INDEX) begin
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (blk_ready) begin
          cnt_d = 5'd0;
          if (extra_pad_q) begin
            extra_pad_d = 1'b0;
            state_d     = PAD;
            blk_count_d = 5'd0;
            blk_last_d  = 1'b1;
          end else begin
            state_d = FILL;
          end
        end
      end

      default: begin
        state_d = FILL;
        cnt_d   = 5'd0;
      end
    endcase

    // Snapshot the key on entry into HOLD; key_shadow_d already carries a
    // same-cycle key_load, which gives the bypass.
    if (state_d == HOLD && state_q != HOLD) begin
      blk_key_d = key_shadow_d;
    end
  end

  // Block register update: one byte lane written at the current count.
  always_comb begin
    data_d = data_q;
    for (int k = 0; k < 16; k++) begin
      if (wr_en && cnt_q == 5'(k)) begin
        if (MSB_FIRST != 0) begin
          data_d[8*(15-k) +: 8] = wr_byte;
        end else begin
          data_d[8*k +: 8] = wr_byte;
        end
      end
    end
  end

  // Registered handshake and status outputs, derived from the next state.
  always_comb begin
    in_ready_d  = (state_d == FILL);
    blk_valid_d = (state_d == HOLD);
    busy_d      = (state_d != FILL) || (cnt_d != 5'd0);
  end

  // State registers; reset discards any partial block, pending pad and
  // extra-pad request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      cnt_q        <= 5'd0;
      // NOTE: the block and key registers are reset too, because the outputs
      // must read as zero after reset; a pure storage array would not need it.
      data_q       <= '0;
      key_shadow_q <= '0;
      blk_key_q    <= '0;
      blk_count_q  <= 5'd0;
      blk_last_q   <= 1'b0;
      extra_pad_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      blk_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // computed before the edge, independent of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      key_shadow_q <= key_shadow_d;
      blk_key_q    <= blk_key_d;
      blk_count_q  <= blk_count_d;
      blk_last_q   <= blk_last_d;
      extra_pad_q  <= extra_pad_d;
      in_ready_q   <= in_ready_d;
      blk_valid_q  <= blk_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign blk_valid = blk_valid_q;
  assign blk_data  = data_q;
  assign blk_key   = blk_key_q;
  assign blk_count = blk_count_q;
  assign blk_last  = blk_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_block_loader.sv
// tb_aes_block_loader
//   Drives one byte stream into two loaders: dut_z (zero padding, MSB-first)
//   and dut_p (PKCS#7, LSB-first). Table-driven message vectors first, then
//   hand-written sequences for exact-fill PKCS#7, backpressure with key
//   change, key bypass and reset during a block.

module tb_aes_block_loader;

  logic         clk;
  logic         rst_n;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic [127:0] key_in;
  logic         key_load;
  logic         blk_ready;

  logic         z_in_ready, z_blk_last, z_blk_valid, z_busy;
  logic [127:0] z_blk_data, z_blk_key;
  logic [4:0]   z_blk_count;
  logic         p_in_ready, p_blk_last, p_blk_valid, p_busy;
  logic [127:0] p_blk_data, p_blk_key;
  logic [4:0]   p_blk_count;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] KEY1 = 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C;
  localparam logic [127:0] KEY2 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] KEY3 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  aes_block_loader #(.PAD_MODE(0), .MSB_FIRST(1)) dut_z (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(z_in_ready),
    .key_in(key_in), .key_load(key_load),
    .blk_data(z_blk_data), .blk_key(z_blk_key), .blk_count(z_blk_count),
    .blk_last(z_blk_last), .blk_valid(z_blk_valid), .blk_ready(blk_ready),
    .busy(z_busy)
  );

  aes_block_loader #(.PAD_MODE(1), .MSB_FIRST(0)) dut_p (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(p_in_ready),
    .key_in(key_in), .key_load(key_load),
    .blk_data(p_blk_data), .blk_key(p_blk_key), .blk_count(p_blk_count),
    .blk_last(p_blk_last), .blk_valid(p_blk_valid), .blk_ready(blk_ready),
    .busy(p_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0]   first;   // first byte; the message is first, first+1, ...
    int           n;       // bytes in message
    bit           last;    // in_last on the final byte
    int           lat;     // cycles from final byte transfer to blk_valid
    logic [127:0] z_data;
    logic [4:0]   z_cnt;
    bit           z_last;
    logic [127:0] p_data;
    logic [4:0]   p_cnt;
    bit           p_last;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive n bytes back-to-back; returns at posedge+1 after the last transfer.
  task automatic send_bytes(input logic [7:0] first, input int n, input bit last_on_final);
    for (int i = 0; i < n; i++) begin
      in_data  = first + 8'(i);
      in_valid = 1'b1;
      in_last  = last_on_final && (i == n - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait (bounded) for blk_valid on the selected loaders; reports cycles
  // waited and whether any selected loader raised in_ready meanwhile.
  task automatic wait_valid(input bit need_z, input bit need_p, output int cyc, output bit saw_ready);
    cyc = 0;
    saw_ready = 1'b0;
    while (!((!need_z || z_blk_valid) && (!need_p || p_blk_valid)) && cyc < 40) begin
      if ((need_z && z_in_ready) || (need_p && p_in_ready)) saw_ready = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic pulse_ready();
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
  endtask

  initial begin
    int  cyc;
    bit  saw_ready;
    bit  stable;
    logic [127:0] hz_data, hz_key;

    vecs[0] = '{8'h00, 16, 1'b0, 0,
                128'h00010203_04050607_08090A0B_0C0D0E0F, 5'd16, 1'b0,
                128'h0F0E0D0C_0B0A0908_07060504_03020100, 5'd16, 1'b0};
    vecs[1] = '{8'hA1, 5, 1'b1, 11,
                128'hA1A2A3A4_A5000000_00000000_00000000, 5'd5, 1'b1,
                128'h0B0B0B0B_0B0B0B0B_0B0B0BA5_A4A3A2A1, 5'd5, 1'b1};
    vecs[2] = '{8'h3C, 1, 1'b1, 15,
                128'h3C000000_00000000_00000000_00000000, 5'd1, 1'b1,
                128'h0F0F0F0F_0F0F0F0F_0F0F0F0F_0F0F0F3C, 5'd1, 1'b1};
    vecs[3] = '{8'h10, 15, 1'b1, 1,
                128'h10111213_14151617_18191A1B_1C1D1E00, 5'd15, 1'b1,
                128'h011E1D1C_1B1A1918_17161514_13121110, 5'd15, 1'b1};

    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    key_in = '0; key_load = 1'b0; blk_ready = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  {z_in_ready, p_in_ready}, 2'b11);
    check("rst_blk_valid", {z_blk_valid, p_blk_valid}, 2'b00);
    check("rst_busy",      {z_busy, p_busy}, 2'b00);
    check("rst_last",      {z_blk_last, p_blk_last}, 2'b00);
    check("rst_count",     {z_blk_count, p_blk_count}, 10'd0);
    check("rst_data",      z_blk_data | p_blk_data, 128'h0);
    check("rst_key",       z_blk_key | p_blk_key, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    load_key(KEY1);

    // ---------------- table-driven messages ----------------
    foreach (vecs[v]) begin
      send_bytes(vecs[v].first, vecs[v].n, vecs[v].last);
      wait_valid(1'b1, 1'b1, cyc, saw_ready);
      check($sformatf("v%0d_latency", v), 128'(cyc), 128'(vecs[v].lat));
      check($sformatf("v%0d_in_ready_low", v), 128'(saw_ready), 128'd0);
      check($sformatf("v%0d_z_data", v), z_blk_data, vecs[v].z_data);
      check($sformatf("v%0d_z_count", v), 128'(z_blk_count), 128'(vecs[v].z_cnt));
      check($sformatf("v%0d_z_last", v), 128'(z_blk_last), 128'(vecs[v].z_last));
      check($sformatf("v%0d_p_data", v), p_blk_data, vecs[v].p_data);
      check($sformatf("v%0d_p_count", v), 128'(p_blk_count), 128'(vecs[v].p_cnt));
      check($sformatf("v%0d_p_last", v), 128'(p_blk_last), 128'(vecs[v].p_last));
      check($sformatf("v%0d_key", v), z_blk_key ^ p_blk_key ^ KEY1, KEY1);
      check($sformatf("v%0d_hold_in_ready", v), {z_in_ready, p_in_ready}, 2'b00);
      pulse_ready();
      check($sformatf("v%0d_after_xfer", v),
            {z_in_ready, p_in_ready, z_blk_valid, p_blk_valid, z_busy, p_busy}, 6'b110000);
    end

    // ---------------- PKCS#7 exact fill: extra pad block ----------------
    send_bytes(8'h40, 16, 1'b1);
    check("xf_valid", {z_blk_valid, p_blk_valid}, 2'b11);
    check("xf_z_blk", {z_blk_data, z_blk_count, z_blk_last},
          {128'h40414243_44454647_48494A4B_4C4D4E4F, 5'd16, 1'b1});
    check("xf_p_blk", {p_blk_data, p_blk_count, p_blk_last},
          {128'h4F4E4D4C_4B4A4948_47464544_43424140, 5'd16, 1'b0});
    pulse_ready();
    check("xf_z_idle", {z_in_ready, z_blk_valid, z_busy}, 3'b100);
    check("xf_p_padding", {p_in_ready, p_blk_valid, p_busy}, 3'b001);
    wait_valid(1'b0, 1'b1, cyc, saw_ready);
    check("xf_p_latency", 128'(cyc), 128'd16);
    check("xf_p_in_ready_low", 128'(saw_ready), 128'd0);
    check("xf_p_extra_blk", {p_blk_data, p_blk_count, p_blk_last},
          {128'h10101010_10101010_10101010_10101010, 5'd0, 1'b1});
    pulse_ready();
    check("xf_p_idle", {p_in_ready, p_blk_valid, p_busy}, 3'b100);

    // ---------------- backpressure with key change ----------------
    send_bytes(8'h50, 16, 1'b0);
    check("bp_valid", {z_blk_valid, p_blk_valid}, 2'b11);
    hz_data = z_blk_data;
    hz_key  = z_blk_key;
    check("bp_z_data", hz_data, 128'h50515253_54555657_58595A5B_5C5D5E5F);
    check("bp_p_data", p_blk_data, 128'h5F5E5D5C_5B5A5958_57565554_53525150);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        key_in = KEY2; key_load = 1'b1;
      end else begin
        key_load = 1'b0;
      end
      in_data = 8'hEE; in_valid = 1'b1;  // must be ignored in HOLD
      @(posedge clk); #1;
      if (z_blk_data !== hz_data || z_blk_key !== KEY1 || p_blk_key !== KEY1 ||
          z_in_ready || p_in_ready || !z_blk_valid || !p_blk_valid ||
          p_blk_data !== 128'h5F5E5D5C_5B5A5958_57565554_53525150)
        stable = 1'b0;
    end
    key_load = 1'b0; in_valid = 1'b0;
    check("bp_stable", 128'(stable), 128'd1);
    check("bp_key_held", hz_key, KEY1);
    pulse_ready();
    send_bytes(8'h60, 16, 1'b0);
    check("bp_next_key", {z_blk_key, p_blk_key}, {KEY2, KEY2});
    check("bp_next_data", z_blk_data, 128'h60616263_64656667_68696A6B_6C6D6E6F);
    pulse_ready();

    // ---------------- key bypass on entry to HOLD ----------------
    send_bytes(8'h70, 15, 1'b0);
    in_data = 8'h7F; in_valid = 1'b1; key_in = KEY3; key_load = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; key_load = 1'b0;
    check("byp_valid", {z_blk_valid, p_blk_valid}, 2'b11);
    check("byp_key", {z_blk_key, p_blk_key}, {KEY3, KEY3});
    pulse_ready();

    // ---------------- reset mid-block ----------------
    send_bytes(8'h80, 7, 1'b0);
    check("mid_busy", {z_busy, p_busy}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {z_in_ready, p_in_ready, z_blk_valid, p_blk_valid, z_busy, p_busy},
          6'b110000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_release", {z_in_ready, p_in_ready, z_blk_valid, p_blk_valid, z_busy, p_busy},
          6'b110000);
    send_bytes(8'h90, 16, 1'b0);
    check("mid_valid", {z_blk_valid, p_blk_valid}, 2'b11);
    check("mid_z_blk", {z_blk_data, z_blk_count, z_blk_last},
          {128'h90919293_94959697_98999A9B_9C9D9E9F, 5'd16, 1'b0});
    check("mid_p_blk", {p_blk_data, p_blk_count, p_blk_last},
          {128'h9F9E9D9C_9B9A9998_97969594_93929190, 5'd16, 1'b0});
    check("mid_key_cleared", z_blk_key | p_blk_key, 128'h0);

    // Reset asserted while a block is held: blk_valid drops without a clock.
    #2 rst_n = 1'b0;
    #1;
    check("hold_async_drop", {z_blk_valid, p_blk_valid, z_in_ready, p_in_ready}, 4'b0011);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
